waveform_gen_core: RTL and testbench
====================================

// Module: waveform_gen_core
// PURPOSE
//  Sample engine downstream of the waveform_ip AXI4-Lite register file; consumes its control/config words.
//  Phase accumulator plus shape generator (saw/triangle/square/DC), then amplitude scale and offset with saturation.
//  Output is one signed sample per transfer on an AXI4-Stream master; tlast marks the final sample of each period.
// PARAMETERS
//  PHASE_W  32  phase accumulator width (bits)
//  DATA_W   16  sample width; signed two's complement
// PORTS
//  ACLK           in   1        system clock
//  ARESETN        in   1        asynchronous, active-low reset
//  cfg_enable     in   1        level; 1 = generate samples
//  cfg_phase_clr  in   1        1-cycle pulse; zero the accumulator
//  cfg_mode       in   2        0 saw, 1 triangle, 2 square, 3 DC
//  cfg_phase_inc  in   PHASE_W  phase step per sample
//  cfg_duty       in   PHASE_W  square threshold; high while phase < duty
//  cfg_amp        in   DATA_W   unsigned Q1.(DATA_W-1); 0x8000 = unity
//  cfg_offset     in   DATA_W   signed offset added after scaling
//  m_axis_tdata   out  DATA_W   output sample
//  m_axis_tvalid  out  1        sample valid
//  m_axis_tready  in   1        downstream ready
//  m_axis_tlast   out  1        last sample of a period (accumulator wrapped)
//  busy           out  1        enabled, or pipeline not empty
//  period_cnt     out  32       completed periods (tlast transfers), wraps mod 2^32
// BEHAVIOUR
//  Reset (async, ARESETN=0): phase=0, all pipeline valids=0, shadows=0, tvalid/tlast/tdata=0, busy=0, period_cnt=0.
//  Pipeline: S1 phase issue -> S2 shape -> S3 scale/offset/saturate (output reg).
//   advance = !m_axis_tvalid | m_axis_tready; stages move only on advance, so all data holds while stalled.
//  Handshake: once tvalid=1, tdata/tlast stay stable until tready=1. No sample is dropped or duplicated.
//  Latency: enable rise -> first tvalid on 3rd ACLK edge, given tready=1.
//  Issue: when enable=1 and advance, S1 takes current phase; then phase <= phase+inc mod 2^PHASE_W.
//   Carry-out of that add sets the sample's last flag.
//  Shadowing: mode/inc/duty/amp/offset are copied into shadow regs at two points:
//   - on the enable 0->1 edge;
//   - on the cycle a last-flagged sample issues.
//   Config writes mid-period therefore take effect from the next period. The pipeline reads shadows only.
//  Shape (s is signed DATA_W; p = issued phase; T = p[PHASE_W-1 -: DATA_W]):
//   saw:  s = {~T[MSB], T[MSB-1:0]}; -2^(D-1) at p=0.
//   tri:  u = p[PHASE_W-2 -: DATA_W], bitwise inverted when p[PHASE_W-1]=1; s = {~u[MSB], u[MSB-1:0]}.
//   sq:   s = (p < duty) ? +(2^(D-1)-1) : -(2^(D-1)-1).
//   DC:   s = 0.
//  Scale: prod = s * signed({1'b0,amp}) (2*DATA_W+1 bits), arithmetic >>> (DATA_W-1).
//   y = prod + sext(offset); saturate y to [-2^(D-1), 2^(D-1)-1].
//  enable 1->0: no new issue; in-flight samples drain normally; phase is held; busy drops when S1..S3 are empty.
//  cfg_phase_clr: phase <= 0 next cycle. It wins over a simultaneous increment; in-flight samples are unaffected.
//  period_cnt: increments on each accepted transfer with tlast=1.
//  Reset mid-stream: outputs clear immediately; after release, the stream restarts from phase 0.
// TESTING (DATA_W=16, PHASE_W=32)
//  1 saw, inc=0x1000_0000, amp=0x8000, off=0, tready=1 -> 0x8000,0x9000,...,0x7000; tlast on 16th; period_cnt=1.
//  2 square, duty=0x4000_0000, same inc -> 4x 0x7FFF then 12x 0x8001 per period; tlast on 16th sample.
//  3 square, amp=0xFFFF, off=0x4000 -> high samples saturate to 0x7FFF, low samples to 0x8000.
//    DC with off=0xF000 -> constant 0xF000.
//  4 saw streaming; tready low for 5 cycles mid-stream -> tvalid stays 1, tdata stable.
//    Sequence after release is gap-free and duplicate-free.
//  5 write inc=0x2000_0000 at sample 5 of a period -> remaining samples of that period keep step 0x1000.
//    Next period starts 0x8000,0xA000,...
//  6 ARESETN low mid-period -> tvalid=0 and period_cnt=0 immediately; after release plus enable, first sample 0x8000.
//    Check also that phase_clr asserted together with an issue gives next sample 0x8000.

Source files
------------

// File: rtl/waveform_gen_core_if.sv
// Purpose: AXI4-Stream sample channel carried between the waveform core and its consumer.
// Signals: tdata (signed sample), tvalid, tready, tlast (final sample of a period).
// Modports: master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface waveform_gen_core_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/waveform_gen_core.sv
// Purpose: phase accumulator + shape generator (saw/triangle/square/DC) followed by
//          amplitude scale, offset and saturation; streams one signed sample per transfer.
// Ports:   ACLK/ARESETN       clock and asynchronous active-low reset
//          cfg_*              control/config words from the register file
//          m_axis             AXI4-Stream master (tdata/tvalid/tready/tlast)
//          busy               enabled, or samples still in flight
//          period_cnt         count of accepted tlast transfers (wraps)
module waveform_gen_core #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_enable,
    input  logic                cfg_phase_clr,
    input  logic [1:0]          cfg_mode,
    input  logic [PHASE_W-1:0]  cfg_phase_inc,
    input  logic [PHASE_W-1:0]  cfg_duty,
    input  logic [DATA_W-1:0]   cfg_amp,
    input  logic [DATA_W-1:0]   cfg_offset,
    waveform_gen_core_if.master m_axis,
    output logic                busy,
    output logic [31:0]         period_cnt
);

    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam logic signed [DATA_W-1:0] S_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_NMAX = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQ  = 2'd2,
        MODE_DC  = 2'd3
    } mode_e;

    // Accumulator, enable history and config shadows
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               en_q, en_d;
    mode_e              sh_mode_q, sh_mode_d;
    logic [PHASE_W-1:0] sh_inc_q, sh_inc_d;
    logic [PHASE_W-1:0] sh_duty_q, sh_duty_d;
    logic [DATA_W-1:0]  sh_amp_q, sh_amp_d;
    logic [DATA_W-1:0]  sh_off_q, sh_off_d;

    // S1: issued phase with the config snapshot it was issued under
    logic               s1_vld_q, s1_vld_d;
    logic               s1_last_q, s1_last_d;
    logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
    mode_e              s1_mode_q, s1_mode_d;
    logic [PHASE_W-1:0] s1_duty_q, s1_duty_d;
    logic [DATA_W-1:0]  s1_amp_q, s1_amp_d;
    logic [DATA_W-1:0]  s1_off_q, s1_off_d;

    // S2: raw shape sample
    logic                     s2_vld_q, s2_vld_d;
    logic                     s2_last_q, s2_last_d;
    logic signed [DATA_W-1:0] s2_samp_q, s2_samp_d;
    logic [DATA_W-1:0]        s2_amp_q, s2_amp_d;
    logic signed [DATA_W-1:0] s2_off_q, s2_off_d;

    // S3: output register
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic [31:0]       pcnt_q, pcnt_d;

    logic               advance;
    logic               en_rise;
    logic               issue;
    logic               carry;
    logic [PHASE_W-1:0] phase_sum;
    mode_e              eff_mode;
    logic [PHASE_W-1:0] eff_inc;
    logic [PHASE_W-1:0] eff_duty;
    logic [DATA_W-1:0]  eff_amp;
    logic [DATA_W-1:0]  eff_off;

    logic [DATA_W-1:0]        saw_t;
    logic [DATA_W-1:0]        tri_u;
    logic signed [DATA_W-1:0] shape;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] y;
    logic signed [DATA_W-1:0] sat;

    // Shape generation from the S1 phase
    always_comb begin
        saw_t = s1_phase_q[PHASE_W-1 -: DATA_W];
        tri_u = s1_phase_q[PHASE_W-2 -: DATA_W];
        shape = '0;
        // Second half of the period runs the triangle back down
        if (s1_phase_q[PHASE_W-1]) begin
            tri_u = ~tri_u;
        end
        case (s1_mode_q)
            MODE_SAW: shape = {~saw_t[DATA_W-1], saw_t[DATA_W-2:0]};
            MODE_TRI: shape = {~tri_u[DATA_W-1], tri_u[DATA_W-2:0]};
            MODE_SQ:  shape = (s1_phase_q < s1_duty_q) ? S_MAX : S_NMAX;
            default:  shape = '0;
        endcase
    end

    // Amplitude scale (unsigned Q1.(DATA_W-1)), offset and saturation from S2
    always_comb begin
        prod = PROD_W'(s2_samp_q) * PROD_W'($signed({1'b0, s2_amp_q}));
        y    = (prod >>> (DATA_W - 1)) + PROD_W'(s2_off_q);
        if (y > PROD_W'(S_MAX)) begin
            sat = S_MAX;
        end else if (y < PROD_W'(S_MIN)) begin
            sat = S_MIN;
        end else begin
            sat = DATA_W'(y);
        end
    end

    // Issue, shadowing and pipeline advance
    always_comb begin
        phase_d    = phase_q;
        en_d       = cfg_enable;
        sh_mode_d  = sh_mode_q;
        sh_inc_d   = sh_inc_q;
        sh_duty_d  = sh_duty_q;
        sh_amp_d   = sh_amp_q;
        sh_off_d   = sh_off_q;
        s1_vld_d   = s1_vld_q;
        s1_last_d  = s1_last_q;
        s1_phase_d = s1_phase_q;
        s1_mode_d  = s1_mode_q;
        s1_duty_d  = s1_duty_q;
        s1_amp_d   = s1_amp_q;
        s1_off_d   = s1_off_q;
        s2_vld_d   = s2_vld_q;
        s2_last_d  = s2_last_q;
        s2_samp_d  = s2_samp_q;
        s2_amp_d   = s2_amp_q;
        s2_off_d   = s2_off_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        pcnt_d     = pcnt_q;

        advance = !out_vld_q || m_axis.tready;
        en_rise = cfg_enable && !en_q;
        issue   = cfg_enable && advance;

        // On the enable edge the shadows load this cycle, so the first issue bypasses them
        eff_mode = en_rise ? mode_e'(cfg_mode) : sh_mode_q;
        eff_inc  = en_rise ? cfg_phase_inc     : sh_inc_q;
        eff_duty = en_rise ? cfg_duty          : sh_duty_q;
        eff_amp  = en_rise ? cfg_amp           : sh_amp_q;
        eff_off  = en_rise ? cfg_offset        : sh_off_q;

        {carry, phase_sum} = {1'b0, phase_q} + {1'b0, eff_inc};

        if (en_rise) begin
            sh_mode_d = mode_e'(cfg_mode);
            sh_inc_d  = cfg_phase_inc;
            sh_duty_d = cfg_duty;
            sh_amp_d  = cfg_amp;
            sh_off_d  = cfg_offset;
        end

        if (issue) begin
            s1_phase_d = phase_q;
            s1_last_d  = carry;
            s1_mode_d  = eff_mode;
            s1_duty_d  = eff_duty;
            s1_amp_d   = eff_amp;
            s1_off_d   = eff_off;
            phase_d    = phase_sum;
            // Period boundary: pending config writes take effect from the next sample
            if (carry) begin
                sh_mode_d = mode_e'(cfg_mode);
                sh_inc_d  = cfg_phase_inc;
                sh_duty_d = cfg_duty;
                sh_amp_d  = cfg_amp;
                sh_off_d  = cfg_offset;
            end
        end

        if (advance) begin
            s1_vld_d   = issue;
            s2_vld_d   = s1_vld_q;
            s2_last_d  = s1_last_q;
            s2_samp_d  = shape;
            s2_amp_d   = s1_amp_q;
            s2_off_d   = $signed(s1_off_q);
            out_vld_d  = s2_vld_q;
            out_last_d = s2_last_q;
            out_data_d = sat;
        end

        if (cfg_phase_clr) begin
            phase_d = '0;
        end

        if (out_vld_q && m_axis.tready && out_last_q) begin
            pcnt_d = pcnt_q + 32'd1;
        end

        busy_d = cfg_enable || s1_vld_d || s2_vld_d || out_vld_d;
    end

    // State registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            phase_q    <= '0;
            en_q       <= 1'b0;
            sh_mode_q  <= MODE_SAW;
            sh_inc_q   <= '0;
            sh_duty_q  <= '0;
            sh_amp_q   <= '0;
            sh_off_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_phase_q <= '0;
            s1_mode_q  <= MODE_SAW;
            s1_duty_q  <= '0;
            s1_amp_q   <= '0;
            s1_off_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_samp_q  <= '0;
            s2_amp_q   <= '0;
            s2_off_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            pcnt_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            en_q       <= en_d;
            sh_mode_q  <= sh_mode_d;
            sh_inc_q   <= sh_inc_d;
            sh_duty_q  <= sh_duty_d;
            sh_amp_q   <= sh_amp_d;
            sh_off_q   <= sh_off_d;
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            s1_phase_q <= s1_phase_d;
            s1_mode_q  <= s1_mode_d;
            s1_duty_q  <= s1_duty_d;
            s1_amp_q   <= s1_amp_d;
            s1_off_q   <= s1_off_d;
            s2_vld_q   <= s2_vld_d;
            s2_last_q  <= s2_last_d;
            s2_samp_q  <= s2_samp_d;
            s2_amp_q   <= s2_amp_d;
            s2_off_q   <= s2_off_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
            busy_q     <= busy_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tlast  = out_last_q;
    assign busy          = busy_q;
    assign period_cnt    = pcnt_q;

endmodule

// File: tb/tb_waveform_gen_core.sv
// Purpose: self-checking bench for waveform_gen_core: table of configuration/sample-index
//          vectors with hand-computed samples, plus sequences for latency, back-pressure,
//          mid-period config writes, phase clear and mid-stream reset.
module tb_waveform_gen_core;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic        cfg_phase_clr;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_phase_inc;
    logic [31:0] cfg_duty;
    logic [15:0] cfg_amp;
    logic [15:0] cfg_offset;
    logic        busy;
    logic [31:0] period_cnt;

    waveform_gen_core_if #(.DATA_W(16)) m_axis ();

    waveform_gen_core #(.PHASE_W(32), .DATA_W(16)) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .cfg_enable    (cfg_enable),
        .cfg_phase_clr (cfg_phase_clr),
        .cfg_mode      (cfg_mode),
        .cfg_phase_inc (cfg_phase_inc),
        .cfg_duty      (cfg_duty),
        .cfg_amp       (cfg_amp),
        .cfg_offset    (cfg_offset),
        .m_axis        (m_axis),
        .busy          (busy),
        .period_cnt    (period_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Accepted transfers, recorded where inputs are stable
    logic [15:0] qd[$];
    logic        ql[$];
    always @(negedge clk) begin
        if (m_axis.tvalid && m_axis.tready) begin
            qd.push_back(m_axis.tdata);
            ql.push_back(m_axis.tlast);
        end
    end

    typedef struct {
        bit          start;
        logic [1:0]  mode;
        logic [31:0] inc;
        logic [31:0] duty;
        logic [15:0] amp;
        logic [15:0] off;
        int          idx;
        logic [15:0] data;
        logic        last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit st, input logic [1:0] md, input logic [31:0] inc,
                       input logic [31:0] duty, input logic [15:0] amp, input logic [15:0] off,
                       input int idx, input logic [15:0] data, input logic last);
        vec_t v;
        v.start = st; v.mode = md; v.inc = inc; v.duty = duty; v.amp = amp; v.off = off;
        v.idx = idx; v.data = data; v.last = last;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((busy || m_axis.tvalid) && k < 200) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(k < 200), 32'd1);
    endtask

    task automatic wait_q(input int n);
        int k = 0;
        while (qd.size() < n && k < 500) begin
            step();
            k++;
        end
        check("sample_wait_timeout", 32'(k < 500), 32'd1);
    endtask

    task automatic start_cfg(input logic [1:0] md, input logic [31:0] inc, input logic [31:0] duty,
                             input logic [15:0] amp, input logic [15:0] off);
        cfg_enable    = 1'b0;
        cfg_phase_clr = 1'b1;
        step();
        cfg_phase_clr = 1'b0;
        cfg_mode      = md;
        cfg_phase_inc = inc;
        cfg_duty      = duty;
        cfg_amp       = amp;
        cfg_offset    = off;
        qd.delete();
        ql.delete();
        cfg_enable    = 1'b1;
    endtask

    task automatic stop();
        cfg_enable = 1'b0;
        drain();
    endtask

    initial begin
        int          bad;
        logic [15:0] held;
        logic [31:0] pc0;
        logic [15:0] exp_d;

        rst_n         = 1'b0;
        cfg_enable    = 1'b0;
        cfg_phase_clr = 1'b0;
        cfg_mode      = 2'd0;
        cfg_phase_inc = 32'h0;
        cfg_duty      = 32'h0;
        cfg_amp       = 16'h0;
        cfg_offset    = 16'h0;
        m_axis.tready = 1'b1;
        repeat (3) step();

        check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("rst_tlast",  32'(m_axis.tlast),  32'd0);
        check("rst_tdata",  32'(m_axis.tdata),  32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_pcnt",   period_cnt,         32'd0);
        rst_n = 1'b1;
        step();

        // Latency: enable rise -> tvalid after the third edge
        cfg_mode = 2'd0; cfg_phase_inc = 32'h1000_0000; cfg_amp = 16'h8000; cfg_offset = 16'h0;
        cfg_enable = 1'b1;
        step(); step();
        check("lat_no_valid_2", 32'(m_axis.tvalid), 32'd0);
        step();
        check("lat_valid_3", 32'(m_axis.tvalid), 32'd1);
        check("lat_first",   32'(m_axis.tdata),  32'h8000);
        stop();

        // Period counter: one full saw period
        pc0 = period_cnt;
        start_cfg(2'd0, 32'h1000_0000, 32'h0, 16'h8000, 16'h0);
        wait_q(17);
        stop();
        check("pcnt_one_period", period_cnt - pc0, 32'd1);

        // Table: start=1 restarts the generator with that config and collects 20 samples
        add(1, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 0,  16'h8000, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 1,  16'h9000, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 8,  16'h0000, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 15, 16'h7000, 1);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 16, 16'h8000, 0);
        add(1, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'h8000, 16'h0000, 0,  16'h7FFF, 0);
        add(0, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'h8000, 16'h0000, 3,  16'h7FFF, 0);
        add(0, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'h8000, 16'h0000, 4,  16'h8001, 0);
        add(0, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'h8000, 16'h0000, 15, 16'h8001, 1);
        add(1, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'hFFFF, 16'h4000, 0,  16'h7FFF, 0);
        add(0, 2'd2, 32'h1000_0000, 32'h4000_0000, 16'hFFFF, 16'h4000, 5,  16'h8000, 0);
        add(1, 2'd3, 32'h1000_0000, 32'h0,         16'h8000, 16'hF000, 0,  16'hF000, 0);
        add(0, 2'd3, 32'h1000_0000, 32'h0,         16'h8000, 16'hF000, 7,  16'hF000, 0);
        add(1, 2'd1, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 0,  16'h8000, 0);
        add(0, 2'd1, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 1,  16'hA000, 0);
        add(0, 2'd1, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 4,  16'h0000, 0);
        add(0, 2'd1, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 8,  16'h7FFF, 0);
        add(0, 2'd1, 32'h1000_0000, 32'h0,         16'h8000, 16'h0000, 12, 16'hFFFF, 0);
        add(1, 2'd0, 32'h1000_0000, 32'h0,         16'h4000, 16'h0000, 0,  16'hC000, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h4000, 16'h0000, 1,  16'hC800, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h4000, 16'h0000, 9,  16'h0800, 0);
        add(1, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h1000, 0,  16'h9000, 0);
        add(0, 2'd0, 32'h1000_0000, 32'h0,         16'h8000, 16'h1000, 15, 16'h7FFF, 1);
        add(1, 2'd0, 32'hFFFF_FFFF, 32'h0,         16'h8000, 16'h0000, 1,  16'h7FFF, 1);
        add(0, 2'd0, 32'hFFFF_FFFF, 32'h0,         16'h8000, 16'h0000, 0,  16'h8000, 0);

        foreach (vecs[i]) begin
            if (vecs[i].start) begin
                start_cfg(vecs[i].mode, vecs[i].inc, vecs[i].duty, vecs[i].amp, vecs[i].off);
                wait_q(20);
                stop();
            end
            check($sformatf("vec%0d_data", i), 32'(qd[vecs[i].idx]), 32'(vecs[i].data));
            check($sformatf("vec%0d_last", i), 32'(ql[vecs[i].idx]), 32'(vecs[i].last));
        end

        // Back-pressure: 5 stalled cycles hold the sample; the stream stays gap/duplicate-free
        start_cfg(2'd0, 32'h1000_0000, 32'h0, 16'h8000, 16'h0);
        wait_q(5);
        m_axis.tready = 1'b0;
        held = m_axis.tdata;
        bad  = 0;
        repeat (5) begin
            step();
            if (!m_axis.tvalid || m_axis.tdata !== held) bad++;
        end
        check("stall_hold", 32'(bad), 32'd0);
        m_axis.tready = 1'b1;
        wait_q(20);
        stop();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            exp_d = 16'h8000 + 16'(i * 16'h1000);
            if (qd[i] !== exp_d) bad++;
        end
        check("stall_sequence", 32'(bad), 32'd0);

        // Mid-period increment write takes effect from the next period
        start_cfg(2'd0, 32'h1000_0000, 32'h0, 16'h8000, 16'h0);
        wait_q(5);
        cfg_phase_inc = 32'h2000_0000;
        wait_q(24);
        stop();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            exp_d = 16'h8000 + 16'(i * 16'h1000);
            if (qd[i] !== exp_d) bad++;
        end
        check("midwrite_old_period", 32'(bad), 32'd0);
        check("midwrite_old_last", 32'(ql[15]), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            exp_d = 16'h8000 + 16'(i * 16'h2000);
            if (qd[16 + i] !== exp_d) bad++;
        end
        check("midwrite_new_period", 32'(bad), 32'd0);
        check("midwrite_new_last", 32'(ql[23]), 32'd1);

        // Phase clear in a cycle that also issues: that sample keeps its phase, the next is phase 0
        start_cfg(2'd0, 32'h1000_0000, 32'h0, 16'h8000, 16'h0);
        wait_q(3);
        cfg_phase_clr = 1'b1;
        step();
        cfg_phase_clr = 1'b0;
        wait_q(10);
        stop();
        check("clr_kept_sample", 32'(qd[6]), 32'hE000);
        check("clr_restart",     32'(qd[7]), 32'h8000);
        check("clr_after",       32'(qd[8]), 32'h9000);

        // Asynchronous reset mid-period
        start_cfg(2'd0, 32'h1000_0000, 32'h0, 16'h8000, 16'h0);
        wait_q(4);
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("arst_pcnt",   period_cnt,         32'd0);
        step();
        rst_n = 1'b1;
        qd.delete();
        ql.delete();
        wait_q(2);
        stop();
        check("arst_first",  32'(qd[0]), 32'h8000);
        check("arst_second", 32'(qd[1]), 32'h9000);
        check("idle_busy",   32'(busy),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
